mem_io_responder: RTL

- Responder end of the CPU's byte-wide memory bus. It takes mem_a, mem_dout and mem_wr from the core, returns mem_din, and drives io_buffer_full.
- Contains the 128 KB unified RAM and the memory-mapped I/O window: UART TX FIFO, UART RX byte port, cycle counter and program-stop flag.
- Sits between the cpu top and the board or UART shim; it is the bus target for all instruction and load/store traffic.

---
 rtl/mem_io_responder.sv | 82 ++++++++
 1 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU byte-bus target with 128 KB RAM, UART TX FIFO / RX port, cycle counter and stop flag
module mem_io_responder #(
  parameter int ADDR_WIDTH    = 17,
  parameter int TX_DEPTH_LOG2 = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        prog_stop,
  output logic        tx_overflow
);
  localparam int DEPTH = 1 << TX_DEPTH_LOG2;
  logic [7:0] ram [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] tx_buf [0:DEPTH-1];
  logic [TX_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [TX_DEPTH_LOG2:0] count;
  logic [31:0] counter, snapshot;
  logic [ADDR_WIDTH-1:0] addr;
  logic [2:0] sub;
  logic [7:0] io_rd;
  logic is_io, rd_acc, wr_acc, ram_wr, tx_wr, push, pop, full;
  logic unused_hi;
  assign unused_hi = ^mem_a[31:18];
  assign is_io = mem_a[17:16] == 2'b11;
  assign addr = mem_a[ADDR_WIDTH-1:0];
  assign sub = mem_a[2:0];
  assign rd_acc = rdy_in && !mem_wr;
  assign wr_acc = rdy_in && mem_wr;
  assign ram_wr = wr_acc && !is_io;
  assign tx_wr = wr_acc && is_io && sub == 3'd0 && mem_dout != 8'h00;
  assign full = count == (TX_DEPTH_LOG2+1)'(DEPTH);
  assign push = tx_wr && !full;
  assign tx_valid = count != '0;
  assign pop = tx_valid && tx_ready;
  assign tx_data = tx_buf[rd_ptr];
  // one slot of margin for a UART write the CPU may already have issued
  assign io_buffer_full = count >= (TX_DEPTH_LOG2+1)'(DEPTH-1);
  always_comb io_rd = sub == 3'd0 ? (rx_valid ? rx_data : 8'h00) :
                      sub == 3'd4 ? counter[7:0] :
                      sub == 3'd5 ? snapshot[15:8] :
                      sub == 3'd6 ? snapshot[23:16] :
                      sub == 3'd7 ? snapshot[31:24] : 8'h00;
  always_ff @(posedge clk_in) begin
    if (ram_wr) ram[addr] <= mem_dout;
    if (push) tx_buf[wr_ptr] <= mem_dout;
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din     <= '0;
      rx_pop      <= 1'b0;
      prog_stop   <= 1'b0;
      tx_overflow <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      counter     <= '0;
      snapshot    <= '0;
    end else begin
      if (rdy_in) counter <= counter + 32'd1;
      if (rd_acc) mem_din <= is_io ? io_rd : ram[addr];
      rx_pop <= rd_acc && is_io && sub == 3'd0 && rx_valid;
      if (rd_acc && is_io && sub == 3'd4) snapshot <= counter;
      if (wr_acc && is_io && sub == 3'd4) prog_stop <= 1'b1;
      if (tx_wr && full) tx_overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end
endmodule
